// File: rtl/cpu_control_pkg.sv
// Shared control definitions for the RV32I CPU: FSM states, opcodes and datapath mux/ALU encodings.
// Both the single-cycle decoder and the multicycle controller import this package.
package cpu_control_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_JAL       = 4'd10,
    S_BRANCH    = 4'd11,
    S_LUI       = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef struct packed {
    logic       memRequest;
    logic       memWrite;
    logic       adrSelect;
    logic       fetch;
    logic       pcUpdate;
    logic       branch;
    logic       regWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] resultSelect;
    logic       illegal;
  } ctrl_t;

  // Moore control word for a state; fetch/pcUpdate/branch are later qualified by mem_ready and zero.
  function automatic ctrl_t stateControls(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memRequest   = 1'b1;
        c.fetch        = 1'b1;
        c.pcUpdate     = 1'b1;
        c.aluSrcA      = SRC_A_PC;
        c.aluSrcB      = SRC_B_FOUR;
        c.aluOp        = ALUOP_ADD;
        c.resultSelect = RES_ALU;
      end
      S_DECODE: begin
        c.aluSrcA = SRC_A_OLDPC;
        c.aluSrcB = SRC_B_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        c.aluSrcA = SRC_A_RS1;
        c.aluSrcB = SRC_B_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        c.memRequest   = 1'b1;
        c.adrSelect    = 1'b1;
        c.resultSelect = RES_ALUOUT;
      end
      S_MEM_WB: begin
        c.resultSelect = RES_READ;
        c.regWrite     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.memRequest   = 1'b1;
        c.memWrite     = 1'b1;
        c.adrSelect    = 1'b1;
        c.resultSelect = RES_ALUOUT;
      end
      S_EXEC_R: begin
        c.aluSrcA = SRC_A_RS1;
        c.aluSrcB = SRC_B_RS2;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        c.aluSrcA = SRC_A_RS1;
        c.aluSrcB = SRC_B_IMM;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        c.resultSelect = RES_ALUOUT;
        c.regWrite     = 1'b1;
      end
      S_JAL: begin
        c.aluSrcA      = SRC_A_OLDPC;
        c.aluSrcB      = SRC_B_FOUR;
        c.aluOp        = ALUOP_ADD;
        c.resultSelect = RES_ALUOUT;
        c.pcUpdate     = 1'b1;
      end
      S_BRANCH: begin
        c.aluSrcA      = SRC_A_RS1;
        c.aluSrcB      = SRC_B_RS2;
        c.aluOp        = ALUOP_SUB;
        c.resultSelect = RES_ALUOUT;
        c.branch       = 1'b1;
      end
      S_LUI: begin
        c.resultSelect = RES_IMM;
        c.regWrite     = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath/memory (slave).
interface multicycle_controller_if #(parameter int COUNT_WIDTH = 32);
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   zero;
  logic                   mem_ready;
  logic                   mem_request;
  logic                   mem_write;
  logic                   adr_select;
  logic                   IR_write;
  logic                   PC_write;
  logic                   reg_write;
  logic [1:0]             ALU_src_A;
  logic [1:0]             ALU_src_B;
  logic [1:0]             ALU_op;
  logic [1:0]             result_select;
  logic                   illegal;
  logic [COUNT_WIDTH-1:0] instr_retired;
  logic [3:0]             state;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output mem_request, mem_write, adr_select, IR_write, PC_write, reg_write,
           ALU_src_A, ALU_src_B, ALU_op, result_select, illegal, instr_retired, state
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  mem_request, mem_write, adr_select, IR_write, PC_write, reg_write,
           ALU_src_A, ALU_src_B, ALU_op, result_select, illegal, instr_retired, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared multicycle RV32I datapath, with memory wait states,
// an absorbing illegal-instruction trap and a retired-instruction counter.
module multicycle_controller
  import cpu_control_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  multicycle_controller_if.master bus
);

  state_t                 r_state;
  state_t                 w_next;
  ctrl_t                  r_ctrl;
  logic [COUNT_WIDTH-1:0] r_retired;
  logic                   w_retire;
  logic                   w_taken;

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_START:     w_next = S_FETCH;
      S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_LUI:            w_next = S_LUI;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH:         w_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  w_next = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    w_next = S_ALU_WB;
      S_EXEC_I:    w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_JAL:       w_next = S_ALU_WB;
      S_BRANCH:    w_next = S_FETCH;
      S_LUI:       w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_TRAP;
    endcase
  end

  // Only final-step states retire; START and TRAP never reach FETCH through this path.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_LUI});

  // Control word is registered for the state being entered, so outputs are glitch-free per state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_START;
      r_ctrl    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= stateControls(w_next);
      if (w_retire) begin
        r_retired <= r_retired + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign w_taken = bus.zero ^ bus.funct3[0];

  assign bus.mem_request   = r_ctrl.memRequest;
  assign bus.mem_write     = r_ctrl.memWrite;
  assign bus.adr_select    = r_ctrl.adrSelect;
  assign bus.IR_write      = r_ctrl.fetch & bus.mem_ready;
  assign bus.PC_write      = (r_ctrl.pcUpdate & (~r_ctrl.fetch | bus.mem_ready)) |
                             (r_ctrl.branch & w_taken);
  assign bus.reg_write     = r_ctrl.regWrite;
  assign bus.ALU_src_A     = r_ctrl.aluSrcA;
  assign bus.ALU_src_B     = r_ctrl.aluSrcB;
  assign bus.ALU_op        = r_ctrl.aluOp;
  assign bus.result_select = r_ctrl.resultSelect;
  assign bus.illegal       = r_ctrl.illegal;
  assign bus.instr_retired = r_retired;
  assign bus.state         = r_state;

endmodule
